// File: rtl/key_sw_debouncer.sv
// Board-input conditioning: synchronises and debounces the active-low KEY[0]
// button and the slide-switch vector, producing clean levels and one-cycle pulses.
module key_sw_debouncer #(
  parameter int CNT_MAX = 500000,
  parameter int SW_W    = 8
) (
  input  logic            MAX10_CLK1_50,
  input  logic            RESET_N,
  input  logic            KEY_IN,
  input  logic [SW_W-1:0] SW_IN,
  output logic            KEY_LEVEL,
  output logic            KEY_PRESS,
  output logic            KEY_RELEASE,
  output logic [SW_W-1:0] SW_OUT,
  output logic            SW_CHG,
  output logic [1:0]      KEY_STATE_DBG
);

  localparam int            CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  logic            key_sync1_q, key_sync1_d;
  logic            key_sync2_q, key_sync2_d;
  logic [SW_W-1:0] sw_sync1_q,  sw_sync1_d;
  logic [SW_W-1:0] sw_sync2_q,  sw_sync2_d;
  logic [SW_W-1:0] sw_prev_q,   sw_prev_d;

  key_state_e      state_q,       state_d;
  logic [CW-1:0]   kcnt_q,        kcnt_d;
  logic            key_level_q,   key_level_d;
  logic            key_press_q,   key_press_d;
  logic            key_release_q, key_release_d;

  logic [CW-1:0]   scnt_q,        scnt_d;
  logic [SW_W-1:0] sw_out_q,      sw_out_d;
  logic            sw_chg_q,      sw_chg_d;

  logic            k_s;

  // Synchroniser chains; key resets to the released (high) level.
  always_comb begin
    key_sync1_d = KEY_IN;
    key_sync2_d = key_sync1_q;
    sw_sync1_d  = SW_IN;
    sw_sync2_d  = sw_sync1_q;
    sw_prev_d   = sw_sync2_q;
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_sync1_q <= 1'b1;
      key_sync2_q <= 1'b1;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      sw_prev_q   <= '0;
    end else begin
      key_sync1_q <= key_sync1_d;
      key_sync2_q <= key_sync2_d;
      sw_sync1_q  <= sw_sync1_d;
      sw_sync2_q  <= sw_sync2_d;
      sw_prev_q   <= sw_prev_d;
    end
  end

  assign k_s = ~key_sync2_q;

  // Key FSM: the counter restarts at zero on every state entry.
  always_comb begin
    state_d       = state_q;
    kcnt_d        = kcnt_q;
    key_level_d   = key_level_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (k_s) begin
          state_d = PRESS_WAIT;
          kcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!k_s) begin
          state_d = IDLE;
          kcnt_d  = '0;
        end else if (kcnt_q == CNT_LAST) begin
          state_d     = HELD;
          kcnt_d      = '0;
          key_level_d = 1'b1;
          key_press_d = 1'b1;
        end else begin
          kcnt_d = kcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!k_s) begin
          state_d = RELEASE_WAIT;
          kcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (k_s) begin
          state_d = HELD;
          kcnt_d  = '0;
        end else if (kcnt_q == CNT_LAST) begin
          state_d       = IDLE;
          kcnt_d        = '0;
          key_level_d   = 1'b0;
          key_release_d = 1'b1;
        end else begin
          kcnt_d = kcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        kcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      kcnt_q        <= '0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kcnt_q        <= kcnt_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  // Switch vector only lands once it has sat unchanged for CNT_MAX cycles,
  // so multi-bit moves update atomically.
  always_comb begin
    scnt_d   = scnt_q;
    sw_out_d = sw_out_q;
    sw_chg_d = 1'b0;
    if ((sw_sync2_q != sw_prev_q) || (sw_sync2_q == sw_out_q)) begin
      scnt_d = '0;
    end else if (scnt_q == CNT_LAST) begin
      scnt_d   = '0;
      sw_out_d = sw_sync2_q;
      sw_chg_d = 1'b1;
    end else begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scnt_q   <= '0;
      sw_out_q <= '0;
      sw_chg_q <= 1'b0;
    end else begin
      scnt_q   <= scnt_d;
      sw_out_q <= sw_out_d;
      sw_chg_q <= sw_chg_d;
    end
  end

  assign KEY_LEVEL     = key_level_q;
  assign KEY_PRESS     = key_press_q;
  assign KEY_RELEASE   = key_release_q;
  assign SW_OUT        = sw_out_q;
  assign SW_CHG        = sw_chg_q;
  assign KEY_STATE_DBG = state_q;

endmodule

// File: tb/tb_key_sw_debouncer.sv
// Bench for key_sw_debouncer: directed scenarios plus random bursts, compared
// every cycle against a window-based behavioural model.
module tb_key_sw_debouncer;

  localparam int CNT_MAX = 4;
  localparam int SW_W    = 8;
  localparam int EW      = SW_W + 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            key_in = 1'b1;
  logic [SW_W-1:0] sw_in  = '0;
  logic            key_level, key_press, key_release, sw_chg;
  logic [SW_W-1:0] sw_out;
  logic [1:0]      key_state_dbg;

  key_sw_debouncer #(.CNT_MAX(CNT_MAX), .SW_W(SW_W)) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N      (rst_n),
    .KEY_IN       (key_in),
    .SW_IN        (sw_in),
    .KEY_LEVEL    (key_level),
    .KEY_PRESS    (key_press),
    .KEY_RELEASE  (key_release),
    .SW_OUT       (sw_out),
    .SW_CHG       (sw_chg),
    .KEY_STATE_DBG(key_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // checking
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: an output level flips once the last CNT_MAX+1
  // synchronised samples all disagree with it; the switch output takes a
  // value once the last CNT_MAX+1 synchronised samples are identical.
  bit              key_pipe[$];
  logic [SW_W-1:0] sw_pipe[$];
  bit              ks_hist[$];
  logic [SW_W-1:0] sw_hist[$];
  bit              m_level = 1'b0;
  logic [SW_W-1:0] m_sw    = '0;
  logic [EW-1:0]   exp_q[$];

  task automatic model_reset();
    key_pipe.delete(); key_pipe.push_back(1'b1); key_pipe.push_back(1'b1);
    sw_pipe.delete();  sw_pipe.push_back('0);    sw_pipe.push_back('0);
    ks_hist.delete();
    sw_hist.delete();
    m_level = 1'b0;
    m_sw    = '0;
    exp_q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit              ks, m_press, m_rel, m_chg, flip, stable;
    logic [SW_W-1:0] sv;
    if (!rst_n) begin
      model_reset();
    end else begin
      ks = !key_pipe[0];
      void'(key_pipe.pop_front());
      key_pipe.push_back(key_in);
      sv = sw_pipe[0];
      void'(sw_pipe.pop_front());
      sw_pipe.push_back(sw_in);

      ks_hist.push_back(ks);
      if (ks_hist.size() > CNT_MAX + 1) void'(ks_hist.pop_front());
      sw_hist.push_back(sv);
      if (sw_hist.size() > CNT_MAX + 1) void'(sw_hist.pop_front());

      m_press = 1'b0; m_rel = 1'b0; m_chg = 1'b0;
      flip = (ks_hist.size() == CNT_MAX + 1);
      for (int i = 0; i < ks_hist.size(); i++) if (ks_hist[i] == m_level) flip = 1'b0;
      if (flip) begin
        m_level = !m_level;
        m_press = m_level;
        m_rel   = !m_level;
      end
      stable = (sw_hist.size() == CNT_MAX + 1) && (sw_hist[0] != m_sw);
      for (int i = 1; i < sw_hist.size(); i++) if (sw_hist[i] != sw_hist[0]) stable = 1'b0;
      if (stable) begin
        m_sw  = sw_hist[0];
        m_chg = 1'b1;
      end
      exp_q.push_back({m_level, m_press, m_rel, m_chg, m_sw});
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {m_level, 1'b0, 1'b0, 1'b0, m_sw};
      check("outs", {key_level, key_press, key_release, sw_chg, sw_out}, e);
    end
  end

  // pulse monitors for the directed scenarios
  int press_cnt = 0, rel_cnt = 0, chg_cnt = 0;
  bit saw_0f = 1'b0, both_pulse = 1'b0;

  always @(negedge clk) begin
    if (key_press)            press_cnt++;
    if (key_release)          rel_cnt++;
    if (sw_chg)               chg_cnt++;
    if (sw_out == 8'h0F)      saw_0f = 1'b1;
    if (key_press && sw_chg)  both_pulse = 1'b1;
  end

  task automatic clr_cnt();
    press_cnt = 0; rel_cnt = 0; chg_cnt = 0; saw_0f = 1'b0; both_pulse = 1'b0;
  endtask

  // drivers
  task automatic drive(input bit k, input logic [SW_W-1:0] s);
    @(negedge clk);
    #1;
    key_in = k;
    sw_in  = s;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit              rk;
    logic [SW_W-1:0] rs;
    int              hold;

    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_state", key_state_dbg, 2'd0);
    wait_cyc(4);
    #1 rst_n = 1'b1;
    wait_cyc(3);

    // clean press
    clr_cnt();
    drive(1'b0, 8'h00);
    wait_cyc(20);
    check("clean_press_cnt", press_cnt, 1);
    check("clean_rel_cnt", rel_cnt, 0);
    check("clean_level", key_level, 1);

    // release from HELD
    clr_cnt();
    drive(1'b1, 8'h00);
    wait_cyc(20);
    check("release_cnt", rel_cnt, 1);
    check("release_level", key_level, 0);

    // bouncy press
    clr_cnt();
    for (int i = 0; i < 6; i++) begin
      drive(i[0], 8'h00);
      wait_cyc(1);
    end
    drive(1'b0, 8'h00);
    wait_cyc(20);
    check("bounce_press_cnt", press_cnt, 1);

    // short release glitch while held
    clr_cnt();
    drive(1'b1, 8'h00);
    wait_cyc(1);
    drive(1'b0, 8'h00);
    wait_cyc(20);
    check("glitch_rel_cnt", rel_cnt, 0);
    check("glitch_press_cnt", press_cnt, 0);
    check("glitch_level", key_level, 1);
    drive(1'b1, 8'h00);
    wait_cyc(20);

    // switch vector
    clr_cnt();
    drive(1'b1, 8'hA5);
    wait_cyc(20);
    check("sw_a5_chg", chg_cnt, 1);
    check("sw_a5_val", sw_out, 8'hA5);
    clr_cnt();
    drive(1'b1, 8'h0F);
    wait_cyc(1);
    drive(1'b1, 8'h3C);
    wait_cyc(20);
    check("sw_3c_chg", chg_cnt, 1);
    check("sw_no_0f", saw_0f, 0);
    check("sw_3c_val", sw_out, 8'h3C);

    // simultaneous key press and switch change
    clr_cnt();
    drive(1'b0, 8'hFF);
    wait_cyc(20);
    check("same_cycle", both_pulse, 1);
    check("same_level", key_level, 1);
    check("same_sw", sw_out, 8'hFF);
    drive(1'b1, 8'hA5);
    wait_cyc(20);
    check("pre_rst_sw", sw_out, 8'hA5);

    // async reset mid PRESS_WAIT
    drive(1'b0, 8'hA5);
    repeat (5) @(posedge clk);
    #3;
    check("mid_pw_level", key_level, 0);
    check("mid_pw_state", key_state_dbg, 2'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {key_level, key_press, key_release, sw_chg, sw_out}, '0);
    check("async_rst_state", key_state_dbg, 2'd0);
    wait_cyc(3);
    clr_cnt();
    #1 rst_n = 1'b1;
    wait_cyc(20);
    check("post_rst_press", press_cnt, 1);
    check("post_rst_chg", chg_cnt, 1);
    check("post_rst_level", key_level, 1);
    check("post_rst_sw", sw_out, 8'hA5);

    // random bursts with mixed hold lengths
    for (int i = 0; i < 80; i++) begin
      rk   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 2) == 0) ? SW_W'($urandom_range(0, 255)) : sw_in;
      hold = $urandom_range(0, 8);
      drive(rk, rs);
      wait_cyc(hold);
    end
    wait_cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
